// File: rtl/cnn_pkg.sv
// Shared types and default dimensions for the CNN streaming pipeline blocks.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int IMG_DIM    = 28;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_phase_t;

    // Address/counter width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for max_pool_2x2: one write port, one combinational read port.
// Contents are not reset; each entry is written in an even row before the odd row reads it.
module pool_line_buf #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int DEPTH      = cnn_pkg::IMG_DIM / 2,
    localparam int ADDR_W    = cnn_pkg::clog2_min1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered frame.
// Result registered on the edge accepting a window's 4th pixel; input stalls while a result is unconsumed.
module max_pool_2x2 #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int IMG_W      = cnn_pkg::IMG_DIM,
    parameter int IMG_H      = cnn_pkg::IMG_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    import cnn_pkg::*;

    localparam int COL_W  = clog2_min1(IMG_W);
    localparam int ROW_W  = clog2_min1(IMG_H);
    localparam int DEPTH  = IMG_W / 2;
    localparam int ADDR_W = clog2_min1(DEPTH);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    function automatic logic [DATA_WIDTH-1:0] smax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    pool_phase_t           r_phase;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;

    logic                  w_acc;
    logic                  w_col_odd;
    logic                  w_col_wrap;
    logic                  w_lb_we;
    logic [ADDR_W-1:0]     w_lb_addr;
    logic [DATA_WIDTH-1:0] w_lb_wdata;
    logic [DATA_WIDTH-1:0] w_lb_rdata;

    assign in_ready   = ~r_out_valid | out_ready;
    assign w_acc      = in_valid & in_ready;
    assign w_col_odd  = r_col[0];
    assign w_col_wrap = (r_col == COL_LAST);
    assign w_lb_addr  = ADDR_W'(r_col >> 1);
    assign w_lb_wdata = smax(r_hold, in_data);
    assign w_lb_we    = w_acc & (r_phase == EVEN_ROW) & w_col_odd;

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_we),
        .i_wr_addr (w_lb_addr),
        .i_wr_data (w_lb_wdata),
        .i_rd_addr (w_lb_addr),
        .o_rd_data (w_lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_phase     <= EVEN_ROW;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_acc) begin
                // A new result here overrides the completion clear above.
                if (r_phase == EVEN_ROW) begin
                    if (!w_col_odd) begin
                        r_hold <= in_data;
                    end
                end else if (!w_col_odd) begin
                    r_hold <= smax(in_data, w_lb_rdata);
                end else begin
                    r_out_data  <= smax(r_hold, in_data);
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_row == ROW_LAST) && w_col_wrap;
                end

                if (w_col_wrap) begin
                    r_col   <= '0;
                    r_phase <= (r_phase == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                    r_row   <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
